// File: rtl/shift_sched.sv
// Two-requester scheduler for a shared 8-bit barrel shifter. The result appears 2 cycles after the grant, and grants are at least 3 cycles apart.
// Backpressure: the result is held in RESP until rsp_ready is seen high, and no requester is granted while a result is held.
module shift_sched #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_din,
  input  logic [2:0] req0_shamt,
  input  logic       req0_lr,
  input  logic       req0_al,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_din,
  input  logic [2:0] req1_shamt,
  input  logic       req1_lr,
  input  logic       req1_al,
  output logic [7:0] sh_din,
  output logic [2:0] sh_shamt,
  output logic       sh_lr,
  output logic       sh_al,
  input  logic [7:0] sh_dout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic [7:0] din;
    logic [2:0] shamt;
    logic       lr;
    logic       al;
    logic       id;
  } op_t;

  state_t state;
  logic   ptr;
  op_t    op;
  logic   pick1;
  logic   can_grant;
  logic   gnt0;
  logic   gnt1;

  // Requester 1 wins only when it is alone or when it holds round-robin priority.
  assign pick1      = req1_valid & (~req0_valid | (RR_EN ? ptr : 1'b0));
  assign can_grant  = rst_n & (state == IDLE);
  assign gnt1       = can_grant & pick1;
  assign gnt0       = can_grant & req0_valid & ~pick1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign sh_din   = op.din;
  assign sh_shamt = op.shamt;
  assign sh_lr    = op.lr;
  assign sh_al    = op.al;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      op        <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_id    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 | gnt1) begin
            op    <= gnt1 ? {req1_din, req1_shamt, req1_lr, req1_al, 1'b1}
                          : {req0_din, req0_shamt, req0_lr, req0_al, 1'b0};
            ptr   <= gnt0;
            state <= ISSUE;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          rsp_data  <= sh_dout;
          rsp_id    <= op.id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sched.sv
// Bench for shift_sched. It runs directed vectors, backpressure, mid-operation reset and arbitration checks.
// It then drives random traffic, which is checked against a transaction-level model.
module tb_shift_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid, req0_ready, req0_lr, req0_al;
  logic [7:0] req0_din;
  logic [2:0] req0_shamt;
  logic       req1_valid, req1_ready, req1_lr, req1_al;
  logic [7:0] req1_din;
  logic [2:0] req1_shamt;
  logic [7:0] sh_din, sh_dout, rsp_data;
  logic [2:0] sh_shamt;
  logic       sh_lr, sh_al, rsp_valid, rsp_ready, rsp_id, busy;

  logic       fp_v0, fp_v1, fp_r0, fp_r1, fp_sh_lr, fp_sh_al;
  logic [7:0] fp_sh_din, fp_rsp_data;
  logic [2:0] fp_sh_shamt;
  logic       fp_rsp_valid, fp_rsp_id, fp_busy;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  shift_sched #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_din(req0_din),
    .req0_shamt(req0_shamt), .req0_lr(req0_lr), .req0_al(req0_al),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_din(req1_din),
    .req1_shamt(req1_shamt), .req1_lr(req1_lr), .req1_al(req1_al),
    .sh_din(sh_din), .sh_shamt(sh_shamt), .sh_lr(sh_lr), .sh_al(sh_al),
    .sh_dout(sh_dout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  shift_sched #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(fp_v0), .req0_ready(fp_r0), .req0_din(8'h11),
    .req0_shamt(3'd1), .req0_lr(1'b1), .req0_al(1'b0),
    .req1_valid(fp_v1), .req1_ready(fp_r1), .req1_din(8'h22),
    .req1_shamt(3'd1), .req1_lr(1'b0), .req1_al(1'b0),
    .sh_din(fp_sh_din), .sh_shamt(fp_sh_shamt), .sh_lr(fp_sh_lr), .sh_al(fp_sh_al),
    .sh_dout(fp_sh_din), .rsp_valid(fp_rsp_valid), .rsp_ready(1'b1),
    .rsp_data(fp_rsp_data), .rsp_id(fp_rsp_id), .busy(fp_busy)
  );

  // Shared shifter: one bit position per step.
  always_comb begin
    sh_dout = sh_din;
    for (int i = 0; i < 7; i++)
      if (i < int'(sh_shamt))
        sh_dout = sh_lr ? {sh_dout[6:0], 1'b0} : {sh_al & sh_din[7], sh_dout[7:1]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s,
                                           input logic lr, input logic al);
    int v;
    if (lr)                v = (int'(d) * (1 << s)) % 256;
    else if (al && d[7])   v = (int'(d) - 256) >>> s;
    else                   v = int'(d) >> s;
    return 8'(v & 255);
  endfunction

  typedef struct {
    bit         who;
    logic [7:0] din;
    logic [2:0] shamt;
    logic       lr;
    logic       al;
    logic [7:0] exp;
    string      name;
  } vec_t;

  function automatic vec_t mk(input bit w, input logic [7:0] d, input logic [2:0] s,
                              input logic lr, input logic al, input logic [7:0] e, input string n);
    vec_t v;
    v.who = w; v.din = d; v.shamt = s; v.lr = lr; v.al = al; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic set_req(input bit who, input logic v, input logic [7:0] d,
                         input logic [2:0] s, input logic lr, input logic al);
    if (who) begin
      req1_valid = v; req1_din = d; req1_shamt = s; req1_lr = lr; req1_al = al;
    end else begin
      req0_valid = v; req0_din = d; req0_shamt = s; req0_lr = lr; req0_al = al;
    end
  endtask

  task automatic single_op(input vec_t v);
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req(!v.who, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    set_req(v.who, 1'b1, v.din, v.shamt, v.lr, v.al);
    #1;
    chk({v.name, " grant"}, v.who ? req1_ready : req0_ready, 1);
    chk({v.name, " other_rdy"}, v.who ? req0_ready : req1_ready, 0);
    @(posedge clk);
    #1;
    set_req(v.who, 1'b0, v.din, v.shamt, v.lr, v.al);
    @(negedge clk);
    chk({v.name, " issue_busy"}, busy, 1);
    chk({v.name, " issue_vld"}, rsp_valid, 0);
    @(negedge clk);
    chk({v.name, " rsp_vld"}, rsp_valid, 1);
    chk({v.name, " rsp_data"}, rsp_data, v.exp);
    chk({v.name, " rsp_id"}, rsp_id, v.who);
    @(negedge clk);
    chk({v.name, " done_vld"}, rsp_valid, 0);
    chk({v.name, " done_busy"}, busy, 0);
  endtask

  vec_t vecs[12];
  int   ids[$];
  int   fp_ids[$];

  bit         m_ptr, m_pend, m_id, e_w1, e_r0, e_r1, e_rv, can;
  int         m_age;
  logic [7:0] m_data;

  initial begin
    vecs[0]  = mk(1'b0, 8'h90, 3'd4, 1'b0, 1'b0, 8'h09, "lsr_90_4");
    vecs[1]  = mk(1'b1, 8'h90, 3'd2, 1'b0, 1'b1, 8'hE4, "asr_90_2");
    vecs[2]  = mk(1'b0, 8'h81, 3'd1, 1'b1, 1'b0, 8'h02, "lsl_81_1");
    vecs[3]  = mk(1'b1, 8'hA5, 3'd0, 1'b0, 1'b0, 8'hA5, "zero_r_l");
    vecs[4]  = mk(1'b0, 8'hA5, 3'd0, 1'b0, 1'b1, 8'hA5, "zero_r_a");
    vecs[5]  = mk(1'b1, 8'hA5, 3'd0, 1'b1, 1'b0, 8'hA5, "zero_l_l");
    vecs[6]  = mk(1'b0, 8'hA5, 3'd0, 1'b1, 1'b1, 8'hA5, "zero_l_a");
    vecs[7]  = mk(1'b1, 8'h3C, 3'd3, 1'b1, 1'b0, 8'hE0, "lsl_3c_3");
    vecs[8]  = mk(1'b0, 8'hF0, 3'd7, 1'b0, 1'b0, 8'h01, "lsr_f0_7");
    vecs[9]  = mk(1'b1, 8'h7F, 3'd7, 1'b0, 1'b1, 8'h00, "asr_7f_7");
    vecs[10] = mk(1'b0, 8'h80, 3'd7, 1'b0, 1'b1, 8'hFF, "asr_80_7");
    vecs[11] = mk(1'b1, 8'h81, 3'd1, 1'b1, 1'b1, 8'h02, "lsl_81_al");

    set_req(1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    set_req(1'b1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    fp_v0 = 1'b0; fp_v1 = 1'b0; rsp_ready = 1'b0;

    // Outputs while held in reset with requests pending
    #12;
    chk("rst ready0", req0_ready, 0);
    chk("rst ready1", req1_ready, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_data", rsp_data, 0);
    chk("rst rsp_id", rsp_id, 0);
    chk("rst busy", busy, 0);
    chk("rst sh_din", sh_din, 0);
    chk("rst sh_shamt", sh_shamt, 0);
    chk("rst sh_lr_al", {sh_lr, sh_al}, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) single_op(vecs[i]);

    // Backpressure: result held for 5 cycles with both requesters waiting
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b1, 8'h90, 3'd2, 1'b0, 1'b1);
    @(posedge clk); #1 req1_valid = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp rsp_valid", rsp_valid, 1);
      chk("bp rsp_data", rsp_data, 8'hE4);
      chk("bp rsp_id", rsp_id, 1);
      chk("bp ready0", req0_ready, 0);
      chk("bp ready1", req1_ready, 0);
      chk("bp busy", busy, 1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp release vld", rsp_valid, 0);
    chk("bp release busy", busy, 0);

    // Reset during ISSUE; the grant to requester 0 moves the pointer before reset
    @(negedge clk);
    set_req(1'b0, 1'b1, 8'h90, 3'd4, 1'b0, 1'b0);
    @(posedge clk); #1 req0_valid = 1'b0;
    #2 req1_valid = 1'b1; rst_n = 1'b0;
    #1;
    chk("mid rst rsp_valid", rsp_valid, 0);
    chk("mid rst rsp_data", rsp_data, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst sh_din", sh_din, 0);
    chk("mid rst sh_shamt", sh_shamt, 0);
    chk("mid rst ready1", req1_ready, 0);
    req1_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post rst no rsp", rsp_valid, 0);
      chk("post rst busy", busy, 0);
    end

    // Both requesters held valid on both instances
    @(negedge clk);
    set_req(1'b0, 1'b1, 8'h0F, 3'd1, 1'b1, 1'b0);
    set_req(1'b1, 1'b1, 8'h0F, 3'd1, 1'b1, 1'b0);
    fp_v0 = 1'b1; fp_v1 = 1'b1; rsp_ready = 1'b1;
    for (int c = 0; c < 40 && (ids.size() < 4 || fp_ids.size() < 4); c++) begin
      @(negedge clk);
      if (rsp_valid && ids.size() < 4) ids.push_back(int'(rsp_id));
      if (fp_rsp_valid && fp_ids.size() < 4) fp_ids.push_back(int'(fp_rsp_id));
    end
    req0_valid = 1'b0; req1_valid = 1'b0; fp_v0 = 1'b0; fp_v1 = 1'b0;
    chk("rr count", ids.size(), 4);
    chk("fp count", fp_ids.size(), 4);
    for (int i = 0; i < ids.size(); i++) chk($sformatf("rr id[%0d]", i), ids[i], i % 2);
    for (int i = 0; i < fp_ids.size(); i++) chk($sformatf("fp id[%0d]", i), fp_ids[i], 0);
    repeat (4) @(negedge clk);
    chk("rr drain busy", busy, 0);

    // Random traffic against a transaction-level model
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_ptr = 1'b0; m_pend = 1'b0; m_age = 0; m_id = 1'b0; m_data = 8'h00;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      set_req(1'b0, 1'($urandom_range(0, 99) < 60), 8'($urandom), 3'($urandom),
              1'($urandom), 1'($urandom));
      set_req(1'b1, 1'($urandom_range(0, 99) < 60), 8'($urandom), 3'($urandom),
              1'($urandom), 1'($urandom));
      rsp_ready = 1'($urandom_range(0, 99) < 70);
      #1;
      can  = !m_pend;
      e_w1 = req1_valid && (!req0_valid || m_ptr);
      e_r1 = can && e_w1;
      e_r0 = can && req0_valid && !e_w1;
      e_rv = m_pend && m_age >= 1;
      chk("rnd ready0", req0_ready, e_r0);
      chk("rnd ready1", req1_ready, e_r1);
      chk("rnd rsp_valid", rsp_valid, e_rv);
      chk("rnd busy", busy, m_pend);
      if (e_rv) begin
        chk("rnd rsp_data", rsp_data, m_data);
        chk("rnd rsp_id", rsp_id, m_id);
      end
      if (can && (req0_valid || req1_valid)) begin
        m_pend = 1'b1;
        m_age  = 0;
        m_id   = e_w1;
        m_data = e_w1 ? ref_shift(req1_din, req1_shamt, req1_lr, req1_al)
                      : ref_shift(req0_din, req0_shamt, req0_lr, req0_al);
        m_ptr  = !e_w1;
      end else if (m_pend) begin
        if (m_age >= 1 && rsp_ready) m_pend = 1'b0;
        else m_age++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("final busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 The block SHALL have one parameter: RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with requester 0 highest.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a shift operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_din  in  8  requester 0 operand.
- req0_shamt  in  3  requester 0 shift amount, 0..7.
- req0_lr  in  1  requester 0 direction: 1 = left, 0 = right.
- req0_al  in  1  requester 0 right-shift fill: 1 = arithmetic (fill din[7]), 0 = logical (fill 0).
- req1_valid, req1_ready, req1_din, req1_shamt, req1_lr, req1_al  same widths and meanings as requester 0, for requester 1.
- sh_din  out  8  operand to the shared 8-bit barrel shifter.
- sh_shamt  out  3  shift amount to the shifter.
- sh_lr  out  1  direction to the shifter.
- sh_al  out  1  fill mode to the shifter.
- sh_dout  in  8  combinational result from the shifter.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  8  shift result.
- rsp_id  out  1  index of the requester that owns rsp_data.
- busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-004 In IDLE, if any reqN_valid is high, the block SHALL grant exactly one requester by asserting its reqN_ready for one cycle.
REQ-005 On the grant cycle the block SHALL capture that requester's din, shamt, lr, al and id into operand registers and go to ISSUE.
REQ-006 reqN_ready SHALL be asserted only combinationally in IDLE and only for the granted requester.
REQ-007 reqN_ready SHALL never be high for both requesters, and never high outside IDLE.
REQ-008 Arbitration with RR_EN=1:
- A 1-bit priority pointer (reset 0) SHALL select the preferred requester when both are valid.
- After each grant the pointer SHALL be set to the requester not granted.
- A single valid requester SHALL be granted regardless of the pointer.
REQ-009 Arbitration with RR_EN=0: requester 0 SHALL always win a simultaneous request; the pointer SHALL be ignored.
REQ-010 sh_din, sh_shamt, sh_lr and sh_al SHALL be driven from the operand registers in every state; they SHALL be 0 after reset.
REQ-011 In ISSUE, the block SHALL register sh_dout into rsp_data and go to RESP; ISSUE SHALL last exactly one cycle.
REQ-012 In RESP, rsp_valid SHALL be 1, and rsp_data and rsp_id SHALL hold stable until rsp_ready is sampled high.
REQ-013 When rsp_valid and rsp_ready are both high, the FSM SHALL return to IDLE on that edge.
REQ-014 No new grant SHALL occur in the cycle rsp_valid and rsp_ready are both high; the minimum spacing between grants SHALL be 3 cycles.
REQ-015 Latency from the grant edge to rsp_valid high SHALL be 2 cycles.
REQ-016 A requester that drops valid before it is granted SHALL lose its request, with no residual state kept.
REQ-017 shamt = 0 SHALL be passed through to the shifter unchanged, and rsp_data SHALL equal din.
REQ-018 busy SHALL be 1 in ISSUE and RESP, and 0 in IDLE.
REQ-019 The block SHALL NOT modify sh_dout; it SHALL only sequence the shifter and register its result.

Reset
REQ-020 rst_n low SHALL immediately, without waiting for a clock edge, force:
- the FSM to IDLE and the pointer to 0;
- the operand registers to 0;
- rsp_valid, rsp_data, rsp_id and busy to 0;
- req0_ready and req1_ready to 0.
REQ-021 Reset asserted mid-operation (ISSUE or RESP) SHALL discard the in-flight result; no response SHALL be emitted for it after reset releases.
REQ-022 The first grant after reset release SHALL NOT occur before the first rising edge on which rst_n is high.

Verification
REQ-023 Single logical right shift: req0 with din=0x90, shamt=4, lr=0, al=0, and rsp_ready=1 -> rsp_valid 2 cycles after the grant, rsp_data=0x09, rsp_id=0.
REQ-024 Arithmetic right and left shifts:
- req1 with din=0x90, shamt=2, lr=0, al=1 -> rsp_data=0xE4, rsp_id=1.
- din=0x81, shamt=1, lr=1 -> rsp_data=0x02.
REQ-025 Round-robin: both requesters held valid for 4 operations with RR_EN=1 -> rsp_id sequence 0,1,0,1; with RR_EN=0 -> 0,0,0,0.
REQ-026 Backpressure: rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable; req0_ready and req1_ready stay 0; busy=1.
REQ-027 Reset mid-operation: rst_n pulsed low during ISSUE -> all outputs 0 asynchronously; no rsp_valid after release until a new grant; the pointer restarts at 0.
REQ-028 Shift by zero: din=0xA5, shamt=0 -> rsp_data=0xA5 for all lr and al combinations.
